// File: rtl/seq_addsub_lcu_if.sv
// Handshake/data bundle between the ALU controller (master) and the
// sequential add/subtract unit (slave).
interface seq_addsub_lcu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             zero;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry_out, zero, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry_out, zero, overflow
  );
endinterface

// File: rtl/seq_addsub_lcu.sv
// Multi-cycle WIDTH-bit adder/subtractor. One 2-bit digit per clock,
// the digit carry is resolved with 2-bit lookahead and registered between
// digits. Subtraction is a + ~b + 1 (carry-in seeded with sub).
// Optional status flags (zero, overflow) are built only when the macro
// SEQ_ADDSUB_FLAGS_EN is defined; otherwise both outputs are tied low.
module seq_addsub_lcu #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  seq_addsub_lcu_if.slave bus
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic             c_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic [2:0]       digit_s;
  logic [WIDTH-1:0] next_acc_s;
`ifdef SEQ_ADDSUB_FLAGS_EN
  logic             zero_r;
  logic             ovf_r;
`endif

  // 2-bit lookahead digit: returns {carry_next, sum1, sum0}.
  function automatic logic [2:0] lcu_digit(input logic [1:0] da,
                                           input logic [1:0] db,
                                           input logic       cin);
    logic [1:0] p;
    logic [1:0] g;
    p = da ^ db;
    g = da & db;
    lcu_digit = {g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin),
                 p[1] ^ (g[0] | (p[0] & cin)),
                 p[0] ^ cin};
  endfunction

  // Current digit result and the accumulator with that digit shifted in at the MSB end.
  always_comb begin
    digit_s    = lcu_digit(a_r[1:0], b_r[1:0], c_r);
    next_acc_s = {digit_s[1:0], acc_r[WIDTH-1:2]};
  end

  // Control FSM, operand/accumulator datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      c_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
`ifdef SEQ_ADDSUB_FLAGS_EN
      zero_r  <= 1'b0;
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            c_r     <= bus.sub;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r <= next_acc_s;
          a_r   <= {2'b00, a_r[WIDTH-1:2]};
          b_r   <= {2'b00, b_r[WIDTH-1:2]};
          c_r   <= digit_s[2];
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            // Last digit: a_r[1]/b_r[1] now hold the original operand MSBs.
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            sum_r   <= next_acc_s;
            carry_r <= digit_s[2];
`ifdef SEQ_ADDSUB_FLAGS_EN
            zero_r  <= (next_acc_s == {WIDTH{1'b0}});
            ovf_r   <= (a_r[1] == b_r[1]) && (digit_s[1] != a_r[1]);
`endif
          end else begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.sum       = sum_r;
  assign bus.carry_out = carry_r;
`ifdef SEQ_ADDSUB_FLAGS_EN
  assign bus.zero      = zero_r;
  assign bus.overflow  = ovf_r;
`else
  assign bus.zero      = 1'b0;
  assign bus.overflow  = 1'b0;
`endif
endmodule

// File: tb/tb_seq_addsub_lcu.sv
// Directed self-checking bench for seq_addsub_lcu (WIDTH=32).
module tb_seq_addsub_lcu;
  localparam int W = 32;
`ifdef SEQ_ADDSUB_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   lat;
  logic saw_done;

  seq_addsub_lcu_if #(.WIDTH(W)) bus ();

  seq_addsub_lcu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge, then scramble the inputs.
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic sub);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = sub;
    tick();
    bus.start = 1'b0;
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'h13579BDF;
    bus.sub   = ~sub;
  endtask

  // Count edges until done, starting from a given cycle count; bounded.
  task automatic wait_done(input int already, output int cycles);
    cycles = already;
    for (int i = 0; i < 40; i++) begin
      tick();
      cycles++;
      if (bus.done === 1'b1) break;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] es, input logic ec,
                              input logic ez, input logic eo);
    check({tag, ".sum"},   bus.sum, es);
    check({tag, ".carry"}, {31'd0, bus.carry_out}, {31'd0, ec});
    check({tag, ".zero"},  {31'd0, bus.zero},      {31'd0, ez & FLAGS});
    check({tag, ".ovf"},   {31'd0, bus.overflow},  {31'd0, eo & FLAGS});
    check({tag, ".busy"},  {31'd0, bus.busy},      32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] es, input logic ec,
                        input logic ez, input logic eo);
    int n;
    drive_start(a, b, sub);
    check({tag, ".busy_after_start"}, {31'd0, bus.busy}, 32'd1);
    wait_done(0, n);
    check({tag, ".latency"}, n, 32'd16);
    check_result(tag, es, ec, ez, eo);
    tick();
    check({tag, ".done_one_cycle"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    check("reset.busy", {31'd0, bus.busy}, 32'd0);
    check("reset.done", {31'd0, bus.done}, 32'd0);
    check_result("reset", 32'd0, 1'b0, 1'b0, 1'b0);

    run_op("add5_3",   32'd5,        32'd3, 1'b0, 32'd8,        1'b0, 1'b0, 1'b0);
    run_op("wrap",     32'hFFFFFFFF, 32'd1, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0);
    run_op("sub5_5",   32'd5,        32'd5, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0);
    run_op("sub3_5",   32'd3,        32'd5, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_op("ovf_add",  32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1);

    // Second start mid-operation is ignored; sum holds the old result meanwhile.
    drive_start(32'd10, 32'd20, 1'b0);
    repeat (4) tick();
    check("hs.sum_held", bus.sum, 32'h80000000);
    check("hs.busy_mid", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b1;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    bus.sub   = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(5, lat);
    check("hs.latency", lat, 32'd16);
    check_result("hs", 32'd30, 1'b0, 1'b0, 1'b0);

    // Start in the done cycle is accepted: back-to-back operation.
    drive_start(32'h12345678, 32'h0F0F0F0F, 1'b0);
    check("b2b.busy", {31'd0, bus.busy}, 32'd1);
    check("b2b.done_low", {31'd0, bus.done}, 32'd0);
    wait_done(0, lat);
    check("b2b.latency", lat, 32'd16);
    check_result("b2b", 32'h21436587, 1'b0, 1'b0, 1'b0);
    tick();

    run_op("ovf_sub",  32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1);

    // Reset mid-operation aborts without a done pulse.
    drive_start(32'h0000FFFF, 32'd1, 1'b0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.done", {31'd0, bus.done}, 32'd0);
    check_result("rst", 32'd0, 1'b0, 1'b0, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
    end
    check("rst.no_done", {31'd0, saw_done}, 32'd0);

    run_op("fresh", 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 32'h4B4B4B4B, 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
